// File: rtl/sram_pkg.sv
// Shared constants and types for the 128x8 flop-based scratch RAM.
package sram_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int ADDR_WIDTH = 7;
    localparam int DEPTH      = 2 ** ADDR_WIDTH;

    typedef logic [DATA_WIDTH-1:0] data_t;
    typedef logic [ADDR_WIDTH-1:0] addr_t;

endpackage : sram_pkg

// File: rtl/sram_word.sv
// One storage word: a DATA_WIDTH register with async active-low clear
// and a write enable. The top instantiates one of these per address.
module sram_word
    import sram_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  write_enable,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out
);

    // Capture data_in when this word is selected; clear immediately on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out <= '0;
        end else if (write_enable) begin
            data_out <= data_in;
        end
    end

endmodule : sram_word

// File: rtl/sram_128x8.sv
// Single-port synchronous RAM, 128 x 8, flop-based storage.
// Access timing: a write is stored at the rising edge where write_enable
// is high; a read loads data_out at the rising edge where read_enable is
// high and data_out then holds until the next enabled read or reset.
// With both enables high, the read mux sees the pre-edge contents, so
// data_out gets the old word (read-before-write).
module sram_128x8
    import sram_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic                  write_enable,
    input  logic                  read_enable,
    output logic [DATA_WIDTH-1:0] data_out
);

    logic [DEPTH-1:0]      word_we;
    logic [DATA_WIDTH-1:0] words [DEPTH];
    logic [DATA_WIDTH-1:0] read_word;

    // One-hot write decoder, gated by write_enable.
    always_comb begin
        word_we = '0;
        if (write_enable) begin
            word_we[address] = 1'b1;
        end
    end

    // Storage array: one register per address.
    for (genvar i = 0; i < DEPTH; i++) begin : g_word
        sram_word u_word (
            .clk          (clk),
            .rst_n        (rst_n),
            .write_enable (word_we[i]),
            .data_in      (data_in),
            .data_out     (words[i])
        );
    end

    // DEPTH:1 read mux; every 7-bit address is a valid word.
    always_comb begin
        read_word = words[address];
    end

    // Registered read port; holds its value when read_enable is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out <= '0;
        end else if (read_enable) begin
            data_out <= read_word;
        end
    end

endmodule : sram_128x8

// File: tb/tb_sram_128x8.sv
// Directed bench for sram_128x8: driver tasks issue accesses on the falling
// edge and push expected read data; a monitor pops and compares after each
// rising edge where a read was accepted.
module tb_sram_128x8;

    logic       clk;
    logic       rst_n;
    logic [7:0] data_in;
    logic [6:0] address;
    logic       write_enable;
    logic       read_enable;
    logic [7:0] data_out;

    logic [7:0] exp_q[$];
    int         n_compared   = 0;
    int         n_mismatched = 0;

    sram_128x8 dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .data_in      (data_in),
        .address      (address),
        .write_enable (write_enable),
        .read_enable  (read_enable),
        .data_out     (data_out)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic we, input logic re,
                         input logic [6:0] a, input logic [7:0] d);
        @(negedge clk);
        write_enable = we;
        read_enable  = re;
        address      = a;
        data_in      = d;
    endtask

    task automatic do_write(input logic [6:0] a, input logic [7:0] d);
        drive(1'b1, 1'b0, a, d);
    endtask

    task automatic do_read(input logic [6:0] a, input logic [7:0] exp);
        exp_q.push_back(exp);
        drive(1'b0, 1'b1, a, 8'h00);
    endtask

    task automatic do_write_read(input logic [6:0] a, input logic [7:0] d,
                                 input logic [7:0] exp_old);
        exp_q.push_back(exp_old);
        drive(1'b1, 1'b1, a, d);
    endtask

    task automatic do_idle();
        drive(1'b0, 1'b0, 7'd0, 8'h00);
    endtask

    task automatic check_now(input string name, input logic [7:0] exp);
        n_compared++;
        if (data_out !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %h, required %h", name, data_out, exp);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(posedge clk) begin
        if (rst_n === 1'b1 && read_enable === 1'b1) begin
            #1;
            n_compared++;
            if (exp_q.size() == 0) begin
                n_mismatched++;
                $display("FAIL unexpected_read: got %h, required no read", data_out);
            end else begin
                automatic logic [7:0] exp = exp_q.pop_front();
                if (data_out !== exp) begin
                    n_mismatched++;
                    $display("FAIL read_data: got %h, required %h", data_out, exp);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst_n        = 1'b0;
        data_in      = 8'h00;
        address      = 7'd0;
        write_enable = 1'b0;
        read_enable  = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1 check_now("reset_value", 8'h00);

        // Make data_out non-zero so the async reset has something to clear.
        do_write(7'd5, 8'h77);
        do_read(7'd5, 8'h77);
        do_idle();

        // Mid-cycle reset with a write pending to address 6.
        drive(1'b1, 1'b0, 7'd6, 8'h99);
        #2 rst_n = 1'b0;
        #1 check_now("async_reset_clear", 8'h00);
        @(negedge clk);
        write_enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Array cleared and pending write lost.
        do_read(7'd0,   8'h00);
        do_read(7'd1,   8'h00);
        do_read(7'd127, 8'h00);
        do_read(7'd5,   8'h00);
        do_read(7'd6,   8'h00);

        // Write then read.
        do_write(7'd0, 8'hAA);
        do_read(7'd0, 8'hAA);

        // Second address, first unaffected.
        do_write(7'd1, 8'hCC);
        do_read(7'd1, 8'hCC);
        do_read(7'd0, 8'hAA);

        // Overwrite.
        do_write(7'd0, 8'h33);
        do_read(7'd0, 8'h33);

        // Hold: no read while address and memory change.
        do_write(7'd127, 8'h5A);
        drive(1'b0, 1'b0, 7'd64, 8'hFF);
        @(negedge clk);
        check_now("hold_no_read", 8'h33);
        do_read(7'd127, 8'h5A);

        // Simultaneous read and write returns the old word.
        do_write(7'd2, 8'h11);
        do_write_read(7'd2, 8'h22, 8'h11);
        do_read(7'd2, 8'h22);

        // A few more scattered addresses.
        do_write(7'd64,  8'hF0);
        do_write(7'd63,  8'h0F);
        do_write(7'd100, 8'h81);
        do_read(7'd63,  8'h0F);
        do_read(7'd100, 8'h81);
        do_read(7'd64,  8'hF0);
        do_read(7'd127, 8'h5A);
        do_read(7'd1,   8'hCC);

        do_idle();
        repeat (3) @(negedge clk);

        n_compared++;
        if (exp_q.size() != 0) begin
            n_mismatched++;
            $display("FAIL queue_drain: got %0d pending, required 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule : tb_sram_128x8
